mux_rr_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares the 4:1 select mux (inputs i1..i4, selects s1/s0) among four requesters.
- Each requester raises its request; the block grants one at a time and drives s1/s0 so the mux routes that requester's input to out.
- Sits directly in front of the mux select pins. Sources and the mux output remain outside this block.

---
 rtl/mux_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that drives the s1/s0 select pins of a shared 4:1 mux.
// Optional forced release after HOLD_MAX cycles: define MUXARB_TIMEOUT_EN.
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255 || (1 << CW) <= HOLD_MAX) begin : g_bad_params
        $error("mux_rr_arbiter: HOLD_MAX must be 1..255 and fit in CW bits");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [1:0] pick, idx;
    logic       found;
    logic       hold_hit;
    logic       release_now;

`ifdef MUXARB_TIMEOUT_EN
    logic [CW-1:0] cnt_q;

    // Counter restarts while idle, so it reads 0 on the first GRANT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == GRANT && cnt_q != CW'(HOLD_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hold_hit = (cnt_q == CW'(HOLD_MAX - 1));
`else
    assign hold_hit = 1'b0;
`endif

    // First requester found searching upward from the one after last grant.
    always_comb begin
        pick  = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign release_now = (state_q == GRANT) && (done || !req[last_q] || hold_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            last_q    <= 2'd3;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = GRANT;
            GRANT:   if (release_now) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Select lines keep their value on release so the mux output stays put.
    always_comb begin
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d  = 4'b0001 << pick;
                    sel_d  = pick;
                    last_d = pick;
                    busy_d = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_d     = 4'b0000;
                    busy_d    = 1'b0;
                    timeout_d = hold_hit && !done && req[last_q];
                end
            end
            default: begin
                gnt_d  = 4'b0000;
                busy_d = 1'b0;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign s1      = sel_q[1];
    assign s0      = sel_q[0];
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter; timeout scenarios follow MUXARB_TIMEOUT_EN.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    mux_rr_arbiter #(.HOLD_MAX(8), .CW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .s1      (s1),
        .s0      (s0),
        .busy    (busy),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || {s1, s0} !== 2'b00 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b sel=%b%b busy=%b timeout=%b, want 0000 00 0 0",
                     gnt, s1, s0, busy, timeout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || {s1, s0} !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b sel=%b%b busy=%b, want 0001 00 1",
                     gnt, s1, s0, busy);
        end
    endtask

    // Grant 0 is already active on entry; all four requesting.
    task automatic test_round_robin();
        logic [1:0] order [5];
        logic [1:0] e;
        logic [3:0] oh;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        for (int i = 0; i < 5; i++) begin
            e  = order[i];
            oh = 4'b0001 << e;
            checks++;
            if (gnt !== oh || {s1, s0} !== e || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant[%0d]: gnt=%b sel=%b%b busy=%b, want %b %b 1",
                         i, gnt, s1, s0, busy, oh, e);
            end
            done = 1'b1;
            if (i == 4) req = 4'b0000;
            @(negedge clk);
            done = 1'b0;
            checks++;
            if (gnt !== 4'b0000 || {s1, s0} !== e || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap[%0d]: gnt=%b sel=%b%b busy=%b, want 0000 %b 0",
                         i, gnt, s1, s0, busy, e);
            end
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL rr_idle[%0d]: gnt=%b, want 0000", i, gnt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_drop();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || {s1, s0} !== 2'b10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b sel=%b%b busy=%b, want 0100 10 1", gnt, s1, s0, busy);
        end
        req = 4'b0101;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || {s1, s0} !== 2'b10) begin
            errors++;
            $display("FAIL single_hold: gnt=%b sel=%b%b, want 0100 10", gnt, s1, s0);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || {s1, s0} !== 2'b10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: gnt=%b sel=%b%b busy=%b, want 0000 10 0", gnt, s1, s0, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || {s1, s0} !== 2'b01) begin
            errors++;
            $display("FAIL to_grant: gnt=%b sel=%b%b, want 0010 01", gnt, s1, s0);
        end
`ifdef MUXARB_TIMEOUT_EN
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold[%0d]: gnt=%b timeout=%b, want 0010 0", c, gnt, timeout);
            end
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1 || {s1, s0} !== 2'b01) begin
            errors++;
            $display("FAIL to_release: gnt=%b timeout=%b sel=%b%b, want 0000 1 01", gnt, timeout, s1, s0);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse_end: gnt=%b timeout=%b, want 0000 0", gnt, timeout);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || {s1, s0} !== 2'b01) begin
            errors++;
            $display("FAIL to_regrant: gnt=%b sel=%b%b, want 0010 01", gnt, s1, s0);
        end
`else
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold[%0d]: gnt=%b timeout=%b, want 0010 0", c, gnt, timeout);
            end
        end
`endif
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_cleanup: gnt=%b timeout=%b, want 0000 0", gnt, timeout);
        end
        repeat (2) @(negedge clk);
    endtask

    // done lands on the same edge where the hold limit would force release.
    task automatic test_done_with_timeout();
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL dt_grant: gnt=%b, want 0001", gnt);
        end
        repeat (7) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 4'b0000;
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dt_release: gnt=%b timeout=%b busy=%b, want 0000 0 0", gnt, timeout, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset(input logic [1:0] k);
        logic [3:0] oh;
        oh  = 4'b0001 << k;
        req = oh;
        @(negedge clk);
        checks++;
        if (gnt !== oh || {s1, s0} !== k) begin
            errors++;
            $display("FAIL mr_grant[%0d]: gnt=%b sel=%b%b, want %b %b", k, gnt, s1, s0, oh, k);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL mr_async[%0d]: gnt=%b busy=%b sel=%b%b, want 0000 0 00", k, gnt, busy, s1, s0);
        end
        req = 4'b1111;
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL mr_restart[%0d]: gnt=%b sel=%b%b, want 0001 00", k, gnt, s1, s0);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_drop();
        test_timeout();
        test_done_with_timeout();
        test_mid_reset(2'd3);
        test_mid_reset(2'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
